uart_cmd_host: RTL
==================

# uart_cmd_host

Host-side initiator for the UART-to-AHB command protocol: accepts a single read or write request on a valid/ready port, serializes it as an 8N1 UART frame (0xA3 write / 0xA5 read, little-endian address and data), and for reads collects the 4-byte little-endian response word. It is the hardware counterpart of the UART command responder, placed in a controller or test-harness SoC so that flash-writer register accesses over UART can be scripted in RTL instead of bench tasks.

## Interface
- CLKS_PER_BIT, 81, HCLK cycles per UART bit (81 ≈ 1.2288 Mbaud at 100 MHz); must be ≥ 4
- RX_TIMEOUT, 1_000_000, HCLK cycles to wait for each response start bit before aborting
- HCLK  in  1  clock; one clock domain
- HRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
- req_write  in  1  1 = write (0xA3), 0 = read (0xA5)
- req_addr  in  32  target address
- req_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse on completion
- rsp_rdata  out  32  read word; valid with rsp_valid on reads, held until the next read completes
- rsp_err  out  1  with rsp_valid: read timeout or RX framing error
- busy  out  1  high from acceptance until rsp_valid inclusive
- tx  out  1  UART line to responder RX; idle high
- rx  in  1  UART line from responder TX; asynchronous

## Operation
- States: IDLE → SEND → (write: DONE | read: RECV) → DONE → IDLE.
- IDLE: req_ready=1. On acceptance, latch addr/wdata/write and build the byte sequence: cmd, A[7:0], A[15:8], A[23:16], A[31:24], then for writes only D[7:0]..D[31:24]. Total 9 bytes for write, 5 for read.
- SEND: each byte is sent as start (0), 8 data bits LSB first, stop (1), each exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no extra idle bits. rx is ignored.
- RECV: rx passes through a 2-FF synchronizer. Wait for a falling edge, then sample at CLKS_PER_BIT/2 (the start bit must still be 0, otherwise it is a glitch: return to waiting without a timeout reset). Sample 8 data bits at CLKS_PER_BIT intervals, then the stop bit. Stop=0 is a framing error: abort to DONE with rsp_err=1. Byte k fills rsp_rdata[8k+7:8k], k=0..3. A 32-bit down-counter loaded with RX_TIMEOUT at the start of each byte wait aborts to DONE with rsp_err=1 at zero.
- DONE: one cycle; rsp_valid=1. On error, rsp_rdata keeps its previous value.
- Edges of rx seen in IDLE, SEND or DONE are discarded. The synchronizer is not flushed.

## Timing
- Reset values: tx=1, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, state=IDLE. Asynchronous HRESET mid-frame forces tx=1 immediately and discards the request; no rsp_valid is produced.
- tx falls (start bit of cmd) in the cycle after acceptance.
- Write latency: acceptance to rsp_valid = 1 + 90·CLKS_PER_BIT cycles (7291 at the default).
- Read: SEND takes 50·CLKS_PER_BIT cycles. RECV ends after the 4th stop-bit sample. rsp_valid follows 1 cycle later. The response line is sampled 2 cycles late because of the synchronizer.
- req_ready drops the cycle after acceptance and re-asserts the cycle after rsp_valid. A req_valid held during DONE is not accepted until IDLE.
- Bit counter counts 0..CLKS_PER_BIT-1. Byte index is 4 bits, with no wrap beyond 8.

## Structure
- Package uart_cmd_pkg: CMD_WR=8'hA3, CMD_RD=8'hA5, state enum (IDLE, SEND, RECV, DONE), byte counts WR_BYTES=9 and RD_BYTES=5.
- One sub-module, uart_rx_byte: synchronizer, start detect, mid-bit sampling, framing check, timeout. Outputs are byte_valid, byte, frame_err and timeout. TX shift logic stays in the top level.

## Test plan
- Write addr=0x0000_0004, data=0x0000_0000 → monitor decodes A3 04 00 00 00 00 00 00 00, each bit 81 cycles. rsp_valid at cycle 7291 after acceptance, rsp_err=0.
- Read addr=0x18, responder model returns bytes 78 56 34 12 → tx bytes A5 18 00 00 00. rsp_rdata=0x1234_5678, rsp_err=0.
- Read with rx held high, RX_TIMEOUT=1000 → rsp_valid with rsp_err=1 about 1000 cycles after the last stop bit. rsp_rdata unchanged.
- Read response with 3rd byte stop bit=0 → rsp_err=1 after that byte, no 4th byte awaited, req_ready back high.
- HRESET pulsed during the 3rd byte of a write → tx=1 immediately, no rsp_valid. A following write 0x8/0x1 produces a clean A3 08 00 00 00 01 00 00 00.
- A 0.3-bit low glitch on rx during RECV → ignored. A correct response that follows still yields the expected word.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_pkg
// Purpose : Shared constants, state encoding and request record for the
//           UART command host (command bytes, frame lengths, byte builder).
// Revision: 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR   = 8'hA3;
  localparam logic [7:0] CMD_RD   = 8'hA5;
  localparam logic [3:0] WR_BYTES = 4'd9;
  localparam logic [3:0] RD_BYTES = 4'd5;

  // Host sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Byte idx of the outgoing frame: command, address LE, then write data LE.
  function automatic logic [7:0] frame_byte(input req_t r, input logic [3:0] idx);
    case (idx)
      4'd0:    return r.write ? CMD_WR : CMD_RD;
      4'd1:    return r.addr[7:0];
      4'd2:    return r.addr[15:8];
      4'd3:    return r.addr[23:16];
      4'd4:    return r.addr[31:24];
      4'd5:    return r.wdata[7:0];
      4'd6:    return r.wdata[15:8];
      4'd7:    return r.wdata[23:16];
      4'd8:    return r.wdata[31:24];
      default: return 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Purpose : 8N1 byte receiver for the response line: 2-FF synchronizer,
//           falling-edge start detect with mid-bit glitch rejection, data and
//           stop sampling, and a per-byte start-bit timeout.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 81,
  parameter int RX_TIMEOUT   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       timeout
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   TMO_LOAD  = 32'(RX_TIMEOUT);

  localparam logic [1:0] R_WAIT  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  logic          rx_meta, rx_sync, rx_prev;
  logic          fall;
  logic [1:0]    rstate;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [31:0]   tmo;

  // Synchronizer runs continuously and is never flushed between transactions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // Byte reception; held in WAIT with the timeout reloaded while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate     <= R_WAIT;
      cnt        <= '0;
      nbit       <= '0;
      tmo        <= TMO_LOAD;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      if (!en) begin
        rstate <= R_WAIT;
        cnt    <= '0;
        nbit   <= '0;
        tmo    <= TMO_LOAD;
      end else begin
        case (rstate)
          R_WAIT: begin
            if (fall) begin
              rstate <= R_START;
              cnt    <= '0;
            end else if (tmo == 32'd0) begin
              timeout <= 1'b1;
            end else begin
              tmo <= tmo - 32'd1;
            end
          end
          R_START: begin
            if (cnt == HALF_LAST) begin
              cnt  <= '0;
              nbit <= '0;
              // A line already back high at mid-start was a glitch; the
              // timeout keeps counting from where it was
              rstate <= rx_sync ? R_WAIT : R_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (cnt == BIT_LAST) begin
              cnt       <= '0;
              byte_data <= {rx_sync, byte_data[7:1]};
              nbit      <= nbit + 3'd1;
              if (nbit == 3'd7) rstate <= R_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            if (cnt == BIT_LAST) begin
              cnt        <= '0;
              byte_valid <= rx_sync;
              frame_err  <= ~rx_sync;
              rstate     <= R_WAIT;
              tmo        <= TMO_LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_host.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_host
// Purpose : Host-side initiator of the UART-to-AHB command protocol. Takes one
//           read/write request, sends it as 8N1 bytes, and for reads gathers
//           the 4-byte little-endian response word.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 81,
  parameter int RX_TIMEOUT   = 1_000_000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        tx,
  input  logic        rx
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  req_t          req;
  logic [3:0]    byte_idx;
  logic [3:0]    bit_idx;
  logic [CW-1:0] clk_cnt;
  logic [23:0]   rx_word;
  logic [7:0]    cur_byte;
  logic [3:0]    last_byte;

  logic          rx_byte_valid;
  logic [7:0]    rx_byte;
  logic          rx_frame_err;
  logic          rx_timeout;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign cur_byte  = frame_byte(req, byte_idx);
  assign last_byte = req.write ? (WR_BYTES - 4'd1) : (RD_BYTES - 4'd1);

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .RX_TIMEOUT   (RX_TIMEOUT)
  ) u_rx (
    .clk        (HCLK),
    .rst        (HRESET),
    .en         (state == ST_RECV),
    .rx         (rx),
    .byte_valid (rx_byte_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_frame_err),
    .timeout    (rx_timeout)
  );

  // Request sequencer: TX bit shifting, response assembly and completion
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      req       <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      clk_cnt   <= '0;
      tx        <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rx_word   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req.write <= req_write;
            req.addr  <= req_addr;
            req.wdata <= req_wdata;
            byte_idx  <= '0;
            bit_idx   <= '0;
            clk_cnt   <= '0;
            tx        <= 1'b0;   // start bit of the command byte
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (byte_idx == last_byte) begin
                tx       <= 1'b1;
                byte_idx <= '0;
                if (req.write) begin
                  rsp_err <= 1'b0;
                  state   <= ST_DONE;
                end else begin
                  state   <= ST_RECV;
                end
              end else begin
                // Next byte's start bit follows the stop bit directly
                byte_idx <= byte_idx + 4'd1;
                tx       <= 1'b0;
              end
            end else begin
              // Leaving bit b: b=0..7 go to data bit b, b=8 goes to stop
              bit_idx <= bit_idx + 4'd1;
              tx      <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (rx_frame_err || rx_timeout) begin
            rsp_err <= 1'b1;       // rsp_rdata keeps the last good word
            state   <= ST_DONE;
          end else if (rx_byte_valid) begin
            case (byte_idx[1:0])
              2'd0:    rx_word[7:0]   <= rx_byte;
              2'd1:    rx_word[15:8]  <= rx_byte;
              2'd2:    rx_word[23:16] <= rx_byte;
              default: begin
                rsp_rdata <= {rx_byte, rx_word};
                rsp_err   <= 1'b0;
                state     <= ST_DONE;
              end
            endcase
            byte_idx <= byte_idx + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
